// File: rtl/rr_priority_arbiter_pkg.sv
// Shared arbiter package: index-width helper and one-hot conversion.
// Imported by the interface, the encoder and the arbiter top.
package arb_pkg;

   localparam int ARB_MAX_N  = 64;
   localparam int ARB_MAX_IW = 6;

   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [ARB_MAX_N-1:0] onehot_of(
      input logic [ARB_MAX_IW-1:0] idx
   );
      return {{(ARB_MAX_N-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Arbiter request/grant bundle with valid/ready on the grant side.
// master: requester side (req, rr_mode, grant_ready); slave: arbiter.
interface rr_priority_arbiter_if #(
   parameter int N = 8
);
   import arb_pkg::*;

   localparam int IDXW = idx_width(N);

   logic [N-1:0]    req;
   logic            rr_mode;
   logic            grant_ready;
   logic            grant_valid;
   logic [IDXW-1:0] grant_idx;
   logic [N-1:0]    grant_onehot;

   modport master (
      output req, rr_mode, grant_ready,
      input  grant_valid, grant_idx, grant_onehot
   );

   modport slave (
      input  req, rr_mode, grant_ready,
      output grant_valid, grant_idx, grant_onehot
   );

endinterface

// File: rtl/rr_priority_arbiter_masked_msb_encoder.sv
// Combinational highest-set-bit finder over (vec & mask).
// Ports: vec, mask in; found, idx (highest set index) out.
module masked_msb_encoder #(
   parameter int N    = 8,
   parameter int IDXW = 3
) (
   input  logic [N-1:0]    vec,
   input  logic [N-1:0]    mask,
   output logic            found,
   output logic [IDXW-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i] && mask[i]) begin
            found = 1'b1;
            idx   = IDXW'(i);
         end
      end
   end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way fixed/round-robin arbiter with registered grant and handshake.
// Ports: clk, rst (sync, active-high), bus (slave view of the bundle).
module rr_priority_arbiter
   import arb_pkg::*;
#(
   parameter  int N    = 8,
   localparam int IDXW = idx_width(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   rr_priority_arbiter_if.slave bus
);

   logic [IDXW-1:0] ptr;
   logic            grant_rr;
   logic            accept;
   logic            arb_en;
   logic [IDXW-1:0] eff_ptr;
   logic [N-1:0]    low_mask;
   logic [N-1:0]    all_mask;
   logic            m_found;
   logic [IDXW-1:0] m_idx;
   logic            u_found;
   logic [IDXW-1:0] u_idx;
   logic [IDXW-1:0] win_idx;
   logic [N-1:0]    win_oh;

   // A grant retired on this edge moves the pointer before the next
   // winner is picked, so back-to-back RR grants rotate without a bubble.
   always_comb begin
      accept   = bus.grant_valid && bus.grant_ready;
      arb_en   = !bus.grant_valid || bus.grant_ready;
      eff_ptr  = (accept && grant_rr) ? bus.grant_idx : ptr;
      all_mask = '1;
      for (int i = 0; i < N; i++) begin
         low_mask[i] = (IDXW'(i) < eff_ptr);
      end
      win_idx = (bus.rr_mode && m_found) ? m_idx : u_idx;
      win_oh  = N'(onehot_of(ARB_MAX_IW'(win_idx)));
   end

   masked_msb_encoder #(.N(N), .IDXW(IDXW)) u_masked (
      .vec   (bus.req),
      .mask  (low_mask),
      .found (m_found),
      .idx   (m_idx)
   );

   masked_msb_encoder #(.N(N), .IDXW(IDXW)) u_full (
      .vec   (bus.req),
      .mask  (all_mask),
      .found (u_found),
      .idx   (u_idx)
   );

   // grant_rr remembers the mode a grant was made in, so a mode flip
   // during backpressure cannot change how its acceptance moves ptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.grant_valid  <= 1'b0;
         bus.grant_idx    <= '0;
         bus.grant_onehot <= '0;
         ptr              <= '0;
         grant_rr         <= 1'b0;
      end else begin
         if (accept && grant_rr) begin
            ptr <= bus.grant_idx;
         end
         if (arb_en) begin
            bus.grant_valid <= u_found;
            grant_rr        <= bus.rr_mode;
            if (u_found) begin
               bus.grant_idx    <= win_idx;
               bus.grant_onehot <= win_oh;
            end else begin
               bus.grant_onehot <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Randomized and directed bench for rr_priority_arbiter (N=8).
// Reference model: rule-level arbitration over plain ints and loops.
module tb_rr_priority_arbiter;

   localparam int N = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   rr_priority_arbiter_if #(.N(N)) bus ();

   rr_priority_arbiter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   bit m_gv;
   int m_idx;
   int m_ptr;
   bit m_rr;

   function automatic int pick(input logic [N-1:0] r, input bit rr,
                               input int p);
      int w;
      w = -1;
      if (rr) begin
         for (int j = N - 1; j >= 0; j--) begin
            if (w < 0 && j < p && r[j]) w = j;
         end
      end
      if (w < 0) begin
         for (int j = N - 1; j >= 0; j--) begin
            if (w < 0 && r[j]) w = j;
         end
      end
      return w;
   endfunction

   task automatic drive(input logic r, input logic [N-1:0] q,
                        input logic md, input logic rdy);
      rst             = r;
      bus.req         = q;
      bus.rr_mode     = md;
      bus.grant_ready = rdy;
   endtask

   // One clock edge: retire the held grant, then arbitrate if allowed.
   task automatic tick();
      int w;
      @(posedge clk);
      if (rst) begin
         m_gv  = 0;
         m_idx = 0;
         m_ptr = 0;
         m_rr  = 0;
      end else begin
         if (m_gv && bus.grant_ready && m_rr) m_ptr = m_idx;
         if (!m_gv || bus.grant_ready) begin
            w    = pick(bus.req, bus.rr_mode, m_ptr);
            m_rr = bus.rr_mode;
            m_gv = (w >= 0);
            if (w >= 0) m_idx = w;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, '0, 1'b0, 1'b1);
      tick();
      tick();
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 8'h00 ||
          bus.grant_idx !== 3'd0) begin
         failures++;
         $display("FAIL reset: valid=%b idx=%0d oh=%b want 0/0/0",
                  bus.grant_valid, bus.grant_idx, bus.grant_onehot);
      end
      drive(1'b0, '0, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 8'h00) begin
            failures++;
            $display("FAIL idle c%0d: valid=%b oh=%b want 0/00000000",
                     c, bus.grant_valid, bus.grant_onehot);
         end
      end
   endtask

   task automatic test_fixed();
      drive(1'b0, 8'b0011_0100, 1'b0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd5 ||
             bus.grant_onehot !== 8'b0010_0000) begin
            failures++;
            $display("FAIL fixed c%0d: valid=%b idx=%0d oh=%b want 1/5/00100000",
                     c, bus.grant_valid, bus.grant_idx, bus.grant_onehot);
         end
      end
   endtask

   task automatic test_rr_rotation();
      int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
      drive(1'b1, '0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 8'hFF, 1'b1, 1'b1);
      foreach (exp_seq[k]) begin
         tick();
         checks++;
         if (bus.grant_valid !== 1'b1 || int'(bus.grant_idx) != exp_seq[k] ||
             bus.grant_onehot !== 8'(1 << exp_seq[k])) begin
            failures++;
            $display("FAIL rr_rot k%0d: valid=%b idx=%0d oh=%b want idx %0d",
                     k, bus.grant_valid, bus.grant_idx, bus.grant_onehot,
                     exp_seq[k]);
         end
      end
   endtask

   task automatic test_sparse_rr();
      int exp_seq[5] = '{7, 4, 1, 7, 4};
      drive(1'b1, '0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 8'b1001_0010, 1'b1, 1'b1);
      foreach (exp_seq[k]) begin
         tick();
         checks++;
         if (bus.grant_valid !== 1'b1 || int'(bus.grant_idx) != exp_seq[k]) begin
            failures++;
            $display("FAIL rr_sparse k%0d: valid=%b idx=%0d want %0d",
                     k, bus.grant_valid, bus.grant_idx, exp_seq[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, '0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 8'hFF, 1'b1, 1'b0);
      tick();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd7) begin
         failures++;
         $display("FAIL bp_first: valid=%b idx=%0d want 1/7",
                  bus.grant_valid, bus.grant_idx);
      end
      drive(1'b0, 8'h01, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd7 ||
             bus.grant_onehot !== 8'h80) begin
            failures++;
            $display("FAIL bp_hold c%0d: valid=%b idx=%0d oh=%b want 1/7/10000000",
                     c, bus.grant_valid, bus.grant_idx, bus.grant_onehot);
         end
      end
      drive(1'b0, 8'hFF, 1'b1, 1'b1);
      tick();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd6) begin
         failures++;
         $display("FAIL bp_release: valid=%b idx=%0d want 1/6",
                  bus.grant_valid, bus.grant_idx);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, '0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 8'hFF, 1'b1, 1'b1);
      tick();
      tick();
      checks++;
      if (bus.grant_idx !== 3'd6) begin
         failures++;
         $display("FAIL rst_mid_pre: idx=%0d want 6", bus.grant_idx);
      end
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      tick();
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_onehot !== 8'h00) begin
         failures++;
         $display("FAIL rst_mid: valid=%b oh=%b want 0/00000000",
                  bus.grant_valid, bus.grant_onehot);
      end
      drive(1'b0, 8'hFF, 1'b1, 1'b1);
      tick();
      checks++;
      if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 3'd7) begin
         failures++;
         $display("FAIL rst_resume: valid=%b idx=%0d want 1/7",
                  bus.grant_valid, bus.grant_idx);
      end
   endtask

   task automatic test_empty();
      drive(1'b0, 8'b0000_1000, 1'b0, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      checks++;
      if (bus.grant_valid !== 1'b0 || bus.grant_idx !== 3'd3 ||
          bus.grant_onehot !== 8'h00) begin
         failures++;
         $display("FAIL empty: valid=%b idx=%0d oh=%b want 0/3/00000000",
                  bus.grant_valid, bus.grant_idx, bus.grant_onehot);
      end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      logic [N-1:0] exp_oh;
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 3))
            0:       r = '0;
            1:       r = 8'(1 << $urandom_range(0, N - 1));
            default: r = 8'($urandom);
         endcase
         drive(($urandom_range(0, 49) == 0), r,
               ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
         tick();
         exp_oh = m_gv ? 8'(1 << m_idx) : 8'h00;
         checks++;
         if (bus.grant_valid !== m_gv || int'(bus.grant_idx) != m_idx ||
             bus.grant_onehot !== exp_oh) begin
            failures++;
            $display("FAIL random k%0d: valid=%b idx=%0d oh=%b want %b/%0d/%b",
                     k, bus.grant_valid, bus.grant_idx, bus.grant_onehot,
                     m_gv, m_idx, exp_oh);
         end
      end
   endtask

   initial begin
      drive(1'b1, '0, 1'b0, 1'b1);
      test_reset();
      test_fixed();
      test_rr_rotation();
      test_sparse_rr();
      test_backpressure();
      test_reset_mid();
      test_empty();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
